// File: rtl/mc_main_control.sv
// Main control FSM for the multicycle MIPS datapath: one instruction at a time
// through fetch/decode/execute/memory/writeback, stalling on shared-memory ready.
module mc_main_control #(
  parameter logic [5:0] OPC_RTYPE = 6'b000000,
  parameter logic [5:0] OPC_LW    = 6'b100011,
  parameter logic [5:0] OPC_SW    = 6'b101011,
  parameter logic [5:0] OPC_BEQ   = 6'b000100,
  parameter logic [5:0] OPC_ADDI  = 6'b001000,
  parameter logic [5:0] OPC_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal_op,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
    MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  ADDIEX = 4'd10, ADDIWB = 4'd11,
    JUMP   = 4'd12
  } state_t;

  state_t st;
  logic   pc_write, branch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else begin
      case (st)
        IDLE:   st <= FETCH;
        FETCH:  if (mem_ready) st <= DECODE;
        DECODE: begin
          case (opcode)
            OPC_LW, OPC_SW: st <= MEMADR;
            OPC_RTYPE:      st <= EXEC;
            OPC_BEQ:        st <= BRANCH;
            OPC_ADDI:       st <= ADDIEX;
            OPC_J:          st <= JUMP;
            default:        st <= FETCH;
          endcase
        end
        MEMADR: st <= (opcode == OPC_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) st <= MEMWB;
        MEMWB:  st <= FETCH;
        MEMWR:  if (mem_ready) st <= FETCH;
        EXEC:   st <= ALUWB;
        ALUWB:  st <= FETCH;
        BRANCH: st <= FETCH;
        ADDIEX: st <= ADDIWB;
        ADDIWB: st <= FETCH;
        JUMP:   st <= FETCH;
        default: st <= IDLE;
      endcase
    end
  end

  logic legal;
  assign legal = opcode inside {OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J};

  // Outputs decode straight from the state register so reset zeroes them at once.
  always_comb begin
    iord = 1'b0; mem_read = 1'b0; mem_write = 1'b0; ir_write = 1'b0;
    reg_dst = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; alu_src_a = 1'b0;
    alu_src_b = 2'b00; alu_op = 2'b00; pc_src = 2'b00;
    illegal_op = 1'b0; instr_done = 1'b0; pc_write = 1'b0; branch = 1'b0;
    case (st)
      FETCH: begin
        mem_read = 1'b1; alu_src_b = 2'b01;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        illegal_op = ~legal; instr_done = ~legal;
      end
      MEMADR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      MEMRD:  begin iord = 1'b1; mem_read = 1'b1; end
      MEMWB:  begin mem_to_reg = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
      MEMWR:  begin iord = 1'b1; mem_write = 1'b1; instr_done = mem_ready; end
      EXEC:   begin alu_src_a = 1'b1; alu_op = 2'b11; end
      ALUWB:  begin reg_dst = 1'b1; reg_write = 1'b1; instr_done = 1'b1; end
      BRANCH: begin
        alu_src_a = 1'b1; alu_op = 2'b10; pc_src = 2'b01;
        branch = 1'b1; instr_done = 1'b1;
      end
      ADDIEX: begin alu_src_a = 1'b1; alu_src_b = 2'b10; end
      ADDIWB: begin reg_write = 1'b1; instr_done = 1'b1; end
      JUMP:   begin pc_src = 2'b10; pc_write = 1'b1; instr_done = 1'b1; end
      default: ;
    endcase
  end

  assign pc_en = pc_write | (branch & zero);
  assign state = st;

endmodule

// File: tb/tb_mc_main_control.sv
// Directed bench for mc_main_control: per-cycle state and output-vector tables.
module tb_mc_main_control;
  logic       clk, rst_n, zero, mem_ready;
  logic [5:0] opcode;
  logic       iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_en, illegal_op, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;
  int nerr = 0, nchk = 0;

  mc_main_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal_op(illegal_op), .instr_done(instr_done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {iord,mem_read,mem_write,ir_write, reg_dst,mem_to_reg,reg_write,alu_src_a,
  //  alu_src_b,alu_op,pc_src, pc_en,illegal_op,instr_done}
  logic [16:0] outs;
  assign outs = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                 alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal_op, instr_done};

  localparam logic [16:0] E_ZERO  = 17'b0;
  localparam logic [16:0] E_FWAIT = {4'b0100, 4'b0000, 2'b01, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_FRDY  = {4'b0101, 4'b0000, 2'b01, 2'b00, 2'b00, 3'b100};
  localparam logic [16:0] E_DEC   = {4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_DILL  = {4'b0000, 4'b0000, 2'b11, 2'b00, 2'b00, 3'b011};
  localparam logic [16:0] E_MADR  = {4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_MRD   = {4'b1100, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_MWB   = {4'b0000, 4'b0110, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [16:0] E_MWRW  = {4'b1010, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_MWRR  = {4'b1010, 4'b0000, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [16:0] E_EXEC  = {4'b0000, 4'b0001, 2'b00, 2'b11, 2'b00, 3'b000};
  localparam logic [16:0] E_ALUWB = {4'b0000, 4'b1010, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [16:0] E_BRT   = {4'b0000, 4'b0001, 2'b00, 2'b10, 2'b01, 3'b101};
  localparam logic [16:0] E_BRN   = {4'b0000, 4'b0001, 2'b00, 2'b10, 2'b01, 3'b001};
  localparam logic [16:0] E_AEX   = {4'b0000, 4'b0001, 2'b10, 2'b00, 2'b00, 3'b000};
  localparam logic [16:0] E_AWB   = {4'b0000, 4'b0010, 2'b00, 2'b00, 2'b00, 3'b001};
  localparam logic [16:0] E_JMP   = {4'b0000, 4'b0000, 2'b00, 2'b00, 2'b10, 3'b101};

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  task automatic test_reset;
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = OP_R;
    @(negedge clk); #1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL reset_state got=%0d want=0", state); end
    nchk++; if (outs !== E_ZERO) begin nerr++; $display("FAIL reset_outs got=%h want=%h", outs, E_ZERO); end
    rst_n = 1'b1; #1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL idle_state got=%0d want=0", state); end
    @(negedge clk); #1;
    nchk++; if (state !== 4'd1) begin nerr++; $display("FAIL idle_to_fetch got=%0d want=1", state); end
    nchk++; if (outs !== E_FWAIT) begin nerr++; $display("FAIL fetch_wait_outs got=%h want=%h", outs, E_FWAIT); end
    @(negedge clk);
  endtask

  task automatic test_rtype;
    bit          mr [5] = '{1, 1, 1, 1, 0};
    logic [3:0]  st [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
    logic [16:0] eo [5] = '{E_FRDY, E_DEC, E_EXEC, E_ALUWB, E_FWAIT};
    opcode = OP_R; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i]; #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL rtype_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      nchk++; if (outs !== eo[i]) begin nerr++; $display("FAIL rtype_outs[%0d] got=%h want=%h", i, outs, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_wait;
    bit          mr [11] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
    logic [3:0]  st [11] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
    logic [16:0] eo [11] = '{E_FWAIT, E_FWAIT, E_FRDY, E_DEC, E_MADR, E_MRD, E_MRD, E_MRD,
                             E_MRD, E_MWB, E_FWAIT};
    opcode = OP_LW;
    for (int i = 0; i < 11; i++) begin
      mem_ready = mr[i]; #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      nchk++; if (outs !== eo[i]) begin nerr++; $display("FAIL lw_outs[%0d] got=%h want=%h", i, outs, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq;
    bit          zr [7] = '{1, 1, 1, 0, 0, 0, 0};
    logic [3:0]  st [7] = '{4'd1, 4'd2, 4'd9, 4'd1, 4'd2, 4'd9, 4'd1};
    logic [16:0] eo [7] = '{E_FRDY, E_DEC, E_BRT, E_FRDY, E_DEC, E_BRN, E_FWAIT};
    opcode = OP_BEQ;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i != 6); zero = zr[i]; #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL beq_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      nchk++; if (outs !== eo[i]) begin nerr++; $display("FAIL beq_outs[%0d] got=%h want=%h", i, outs, eo[i]); end
      @(negedge clk);
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_j_addi;
    logic [5:0]  op [13] = '{OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_J, OP_J, OP_J,
                             OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI};
    bit          mr [13] = '{1, 0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [3:0]  st [13] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd6, 4'd1, 4'd2, 4'd12,
                             4'd1, 4'd2, 4'd10, 4'd11, 4'd1};
    logic [16:0] eo [13] = '{E_FRDY, E_DEC, E_MADR, E_MWRW, E_MWRR, E_FRDY, E_DEC, E_JMP,
                             E_FRDY, E_DEC, E_AEX, E_AWB, E_FWAIT};
    for (int i = 0; i < 13; i++) begin
      opcode = op[i]; mem_ready = mr[i]; #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL swjaddi_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      nchk++; if (outs !== eo[i]) begin nerr++; $display("FAIL swjaddi_outs[%0d] got=%h want=%h", i, outs, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal;
    logic [3:0]  st [3] = '{4'd1, 4'd2, 4'd1};
    logic [16:0] eo [3] = '{E_FRDY, E_DILL, E_FWAIT};
    opcode = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 0); #1;
      nchk++; if (state !== st[i]) begin nerr++; $display("FAIL illegal_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      nchk++; if (outs !== eo[i]) begin nerr++; $display("FAIL illegal_outs[%0d] got=%h want=%h", i, outs, eo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid;
    opcode = OP_LW; mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0; #1;
    nchk++; if (state !== 4'd4) begin nerr++; $display("FAIL midrst_pre got=%0d want=4", state); end
    #2 rst_n = 1'b0; #1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL midrst_state got=%0d want=0", state); end
    nchk++; if (outs !== E_ZERO) begin nerr++; $display("FAIL midrst_outs got=%h want=%h", outs, E_ZERO); end
    @(negedge clk); rst_n = 1'b1; #1;
    nchk++; if (state !== 4'd0) begin nerr++; $display("FAIL midrst_idle got=%0d want=0", state); end
    @(negedge clk); #1;
    nchk++; if (state !== 4'd1) begin nerr++; $display("FAIL midrst_fetch got=%0d want=1", state); end
    nchk++; if (outs !== E_FWAIT) begin nerr++; $display("FAIL midrst_fetch_outs got=%h want=%h", outs, E_FWAIT); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_sw_j_addi();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
